data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/dmem_pkg.sv | 61 ++++++
 rtl/data_mem_ctrl_if.sv | 25 ++
 rtl/dmem_array.sv | 27 ++
 rtl/data_mem_ctrl.sv | 113 +++++++++++
 tb/tb_data_mem_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data memory controller.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } dmem_state_t;

    // Size 11 and any access not naturally aligned to its size is rejected.
    function automatic logic is_bad(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << lane;
            SZ_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across lanes; the byte enables pick the live lane(s).
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            SZ_B:    w = {4{d[7:0]}};
            SZ_H:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] lane, input logic sgn);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_B:    r = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_H:    r = {{16{sgn & sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store client and the data memory controller.
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic              wr_en;
    logic [1:0]        size;
    logic              sgn;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ack;
    logic              busy;
    logic              err;

    modport master (
        output req, wr_en, size, sgn, adr, wdata,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, wr_en, size, sgn, adr, wdata,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and combinational read; never reset.
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Byte-lane write; lanes with be_i low keep their contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// Wait-stated byte/half/word load-store controller in front of dmem_array.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH) + 2,
    parameter int WAIT   = 2
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_ctrl_if.slave  bus
);

    localparam int         IDX_W    = ADDR_W - 2;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic [ADDR_W-1:0] adr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       dout_q, dout_d;

    logic              latch;
    logic              access;
    logic              bad;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;

    assign bad    = is_bad(size_q, adr_q[1:0]);
    assign mem_be = lane_be(size_q, adr_q[1:0]);

    // Next-state, counter and access strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        access  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    latch   = 1'b1;
                    cnt_d   = WAIT_CNT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_we = access & wr_q & ~bad;

    // Load result only updates on a good load; stores and rejects leave it alone.
    always_comb begin
        dout_d = dout_q;
        if (access && !wr_q && !bad) dout_d = load_ext(mem_rdata, size_q, adr_q[1:0], sgn_q);
    end

    // FSM, counter, request capture and load result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= SZ_B;
            sgn_q   <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            if (latch) begin
                wr_q    <= bus.wr_en;
                size_q  <= bus.size;
                sgn_q   <= bus.sgn;
                adr_q   <= bus.adr;
                wdata_q <= bus.wdata;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .idx_i   (adr_q[ADDR_W-1:2]),
        .wdata_i (lane_wdata(size_q, wdata_q)),
        .rdata_o (mem_rdata)
    );

    assign bus.rdata = dout_q;
    assign bus.ack   = (state_q == ST_DONE);
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.err   = (state_q == ST_DONE) & bad;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: WAIT=2 instance for data paths, WAIT=0 instance for back-to-back requests.
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    localparam int ADDR_W = 8;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus  ();
    data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus0 ();

    data_mem_ctrl #(.DEPTH(64), .ADDR_W(ADDR_W), .WAIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    data_mem_ctrl #(.DEPTH(64), .ADDR_W(ADDR_W), .WAIT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the WAIT=2 instance idle; returns at a negedge with it idle again.
    task automatic acc(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [7:0] a, input logic [31:0] d,
                       input logic exp_err, input logic [31:0] exp_dout);
        int   cyc;
        logic seen;
        logic e_at_ack;
        logic b_at_ack;
        bus.req   = 1'b1;
        bus.wr_en = wr;
        bus.size  = sz;
        bus.sgn   = sg;
        bus.adr   = a;
        bus.wdata = d;
        @(posedge clk);
        #1 bus.req = 1'b0;
        cyc = 0;
        seen = 1'b0;
        e_at_ack = 1'b0;
        b_at_ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!seen) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (bus.ack) begin
                    seen = 1'b1;
                    e_at_ack = bus.err;
                    b_at_ack = bus.busy;
                end
            end
        end
        chk({tag, " latency"}, cyc, 3);
        chk({tag, " err"}, {31'd0, e_at_ack}, {31'd0, exp_err});
        chk({tag, " busy@ack"}, {31'd0, b_at_ack}, 32'd1);
        @(negedge clk);
        chk({tag, " ack pulse"}, {31'd0, bus.ack}, 32'd0);
        chk({tag, " dout"}, bus.rdata, exp_dout);
    endtask

    initial begin
        logic ack_seen;
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.req = 1'b0;  bus.wr_en = 1'b0; bus.size = SZ_W; bus.sgn = 1'b0;
        bus.adr = '0;    bus.wdata = '0;
        bus0.req = 1'b0; bus0.wr_en = 1'b0; bus0.size = SZ_W; bus0.sgn = 1'b0;
        bus0.adr = '0;   bus0.wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst ack",  {31'd0, bus.ack},  32'd0);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst err",  {31'd0, bus.err},  32'd0);
        chk("rst dout", bus.rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        acc("st w 08",    1'b1, SZ_W,  1'b0, 8'h08, 32'hDEADBEEF, 1'b0, 32'h00000000);
        acc("ld w 08",    1'b0, SZ_W,  1'b0, 8'h08, 32'h0,        1'b0, 32'hDEADBEEF);
        acc("st b 09",    1'b1, SZ_B,  1'b0, 8'h09, 32'hAAAAAA80, 1'b0, 32'hDEADBEEF);
        acc("ld bs 09",   1'b0, SZ_B,  1'b1, 8'h09, 32'h0,        1'b0, 32'hFFFFFF80);
        acc("ld bu 09",   1'b0, SZ_B,  1'b0, 8'h09, 32'h0,        1'b0, 32'h00000080);
        acc("ld w 08b",   1'b0, SZ_W,  1'b0, 8'h08, 32'h0,        1'b0, 32'hDEAD80EF);
        acc("ld hs 0A",   1'b0, SZ_H,  1'b1, 8'h0A, 32'h0,        1'b0, 32'hFFFFDEAD);
        acc("ld hu 0A",   1'b0, SZ_H,  1'b0, 8'h0A, 32'h0,        1'b0, 32'h0000DEAD);
        acc("st w 0C",    1'b1, SZ_W,  1'b0, 8'h0C, 32'h11223344, 1'b0, 32'h0000DEAD);
        acc("ld w 0C",    1'b0, SZ_W,  1'b0, 8'h0C, 32'h0,        1'b0, 32'h11223344);
        acc("st w 0D bad",1'b1, SZ_W,  1'b0, 8'h0D, 32'h55667788, 1'b1, 32'h11223344);
        acc("ld w 0C kept",1'b0, SZ_W, 1'b0, 8'h0C, 32'h0,        1'b0, 32'h11223344);
        acc("st h 0E",    1'b1, SZ_H,  1'b0, 8'h0E, 32'h1234BEEF, 1'b0, 32'h11223344);
        acc("ld w 0C h",  1'b0, SZ_W,  1'b0, 8'h0C, 32'h0,        1'b0, 32'hBEEF3344);
        acc("ld hu 0C",   1'b0, SZ_H,  1'b0, 8'h0C, 32'h0,        1'b0, 32'h00003344);
        acc("ld bs 0F",   1'b0, SZ_B,  1'b1, 8'h0F, 32'h0,        1'b0, 32'hFFFFFFBE);
        acc("ld sz11",    1'b0, 2'b11, 1'b0, 8'h0C, 32'h0,        1'b1, 32'hFFFFFFBE);
        acc("ld h 0B bad",1'b0, SZ_H,  1'b1, 8'h0B, 32'h0,        1'b1, 32'hFFFFFFBE);
        acc("st w 10",    1'b1, SZ_W,  1'b0, 8'h10, 32'hCAFEF00D, 1'b0, 32'hFFFFFFBE);

        // Reset in the middle of the wait window must drop the store.
        bus.req = 1'b1; bus.wr_en = 1'b1; bus.size = SZ_W; bus.sgn = 1'b0;
        bus.adr = 8'h10; bus.wdata = 32'h12345678;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        chk("abort busy pre", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy now", {31'd0, bus.busy}, 32'd0);
        chk("abort ack now",  {31'd0, bus.ack},  32'd0);
        chk("abort dout",     bus.rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ack_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            ack_seen = ack_seen | bus.ack;
        end
        chk("abort no ack", {31'd0, ack_seen}, 32'd0);
        acc("ld w 10 kept", 1'b0, SZ_W, 1'b0, 8'h10, 32'h0, 1'b0, 32'hCAFEF00D);

        // WAIT=0 with req held high: accept, DONE, IDLE, accept ...
        bus0.req = 1'b1; bus0.wr_en = 1'b1; bus0.size = SZ_W; bus0.adr = 8'h20;
        bus0.wdata = 32'h0BADF00D;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("stream busy %0d", k), {31'd0, bus0.busy}, {31'd0, (k % 3) != 0});
            chk($sformatf("stream ack %0d", k),  {31'd0, bus0.ack},  {31'd0, (k % 3) == 2});
        end
        bus0.req = 1'b0;
        repeat (3) @(negedge clk);
        bus0.req = 1'b1; bus0.wr_en = 1'b0; bus0.size = SZ_H; bus0.sgn = 1'b1; bus0.adr = 8'h22;
        @(posedge clk);
        #1 bus0.req = 1'b0;
        repeat (3) @(negedge clk);
        chk("stream ld hs 22", bus0.rdata, 32'h00000BAD);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
